mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port access arbiter placed directly upstream of the single-ported 64K-byte, 16-bit-wide data/instruction memory. It accepts fetch and data requests, grants one at a time, and models a fixed multi-cycle memory latency. It presents exactly one single-cycle enable pulse to the memory per access and returns read data and a done pulse to the winner. The losing port is held in stall.

## Interface
- `LATENCY`, default 2: cycles from grant to the memory-enable cycle, inclusive; legal range 1..15.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `if_req` in 1: fetch request; held high with `if_addr` stable until `if_done`.
- `if_addr` in 16: fetch byte address.
- `if_rdata` out 16: fetch read data; valid while `if_done`=1.
- `if_done` out 1: one-cycle completion pulse for fetch.
- `if_stall` out 1: `if_req` & ~`if_done`.
- `dm_req` in 1: data request; held high with its address and data stable until `dm_done`.
- `dm_wr` in 1: 1 = write, 0 = read.
- `dm_addr` in 16: data byte address.
- `dm_wdata` in 16: write data.
- `dm_rdata` out 16: data read data; valid while `dm_done`=1.
- `dm_done` out 1: one-cycle completion pulse for data.
- `dm_stall` out 1: `dm_req` & ~`dm_done`.
- `mem_enable` out 1: memory enable.
- `mem_wr` out 1: memory write strobe.
- `mem_addr` out 16: memory address.
- `mem_data_in` out 16: write data to memory.
- `mem_data_out` in 16: combinational read data from memory.
- `err` out 1: alignment error, qualified by either done pulse.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If any request is pending, latch the grant owner plus address, write flag and write data into registers.
  - Load `cnt` = LATENCY-1 and go to BUSY.
- **Priority**
  - Data wins over fetch by default.
  - Exception: if the previous grant went to data and both are now pending, fetch wins. This is a one-shot `last_dm` flag, so neither port starves.
- **BUSY**
  - If `cnt` ≠ 0, decrement it.
  - If `cnt` = 0, drive `mem_enable`=1 and `mem_wr` = latched wr. Drive `mem_addr` and `mem_data_in` from the latches.
  - Register `mem_data_out` into the owner's rdata register on that edge, then go to DONE.
- **Memory signals outside the enable cycle:** `mem_enable`, `mem_wr` and `mem_data_in` are 0; `mem_addr` holds its latched value.
- **DONE**
  - Pulse the owner's done for one cycle with rdata valid, then return to IDLE.
  - Requests are not sampled in DONE.
  - A request still high in the following IDLE cycle is a new access.
- **Write completion:** a write's done carries rdata = 0.
- **rdata hold:** each port's rdata register holds its value until that port's next completion.

## Timing
- Request seen in IDLE at cycle 0. Enable cycle = cycle LATENCY. Done = cycle LATENCY+1.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- Exactly one enable pulse per access, so each write takes effect exactly once, on the enable-cycle edge.
- **Reset values:** all outputs 0, state IDLE, `last_dm`=0, `cnt`=0, rdata registers 0.
- **Reset asserted before the enable-cycle edge:** the access is aborted, no memory write occurs, and no done is issued.
- **Request dropped before done:** protocol violation; the latched copy completes regardless.
- Address arithmetic is 16-bit. Addr 0xFFFF passes through unchanged; wrap handling belongs to the memory.

## Configuration
- Macro: `MEM_ARB_ALIGN_CHECK_EN`.
- **Defined**
  - A latched address with bit 0 = 1 never enables the memory: `mem_enable` stays 0 in the enable cycle.
  - Done still pulses at cycle LATENCY+1 with `err`=1 and rdata 0.
  - Aligned accesses behave as normal with `err`=0.
- **Undefined**
  - `err` is tied to 0.
  - Odd addresses pass straight through to the memory.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE, BUSY, DONE);
  - owner encoding (OWN_IF=0, OWN_DM=1);
  - counter width constant (4).
- Single module; the FSM, counter and latches are small enough that no sub-module is warranted.

## Test plan
- **Fetch read:** LATENCY=2, memory preloaded 0x1000:0xABCD, `if_req` with addr 0x1000.
  - Expect: `mem_enable` high only in cycle 2; `if_done` in cycle 3 with `if_rdata`=0xABCD; `if_stall` high in cycles 0–2.
- **Data write then read:** `dm_wr` addr 0x0040 data 0x1234, then a read of 0x0040.
  - Expect: exactly one enable cycle with `mem_wr`=1; the read returns 0x1234.
- **Simultaneous requests:** both requests high at cycle 0.
  - Expect: data granted first (`dm_done` cycle 3); fetch granted in the next IDLE (`if_done` cycle 7).
  - Expect: on a repeated collision, fetch wins next.
- **Reset mid-access:** `rst` pulsed in cycle 1 of a write to 0x0080.
  - Expect: memory at 0x0080 unchanged; no done; all outputs 0 immediately.
- **Odd address with `MEM_ARB_ALIGN_CHECK_EN`:** `dm_req` read at 0x0011.
  - Expect: `mem_enable` never high; `dm_done` and `err` at cycle 3; rdata 0.
  - Without the macro: normal access, `err` 0.
- **LATENCY=1:** read of 0x0002.
  - Expect: enable in cycle 1, done in cycle 2; back-to-back reads complete every 3 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bus of the fetch/data arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_data_out,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_enable, mem_wr, mem_addr, mem_data_in, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_data_out,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_enable, mem_wr, mem_addr, mem_data_in, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data to single-port memory arbiter with fixed access latency.
// Optional MEM_ARB_ALIGN_CHECK_EN: odd addresses skip the memory and report err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t           r_state, w_state_nxt;
    owner_t           r_owner;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [15:0]      r_addr, r_wdata, r_if_rdata, r_dm_rdata;
    logic             r_wr, r_last_dm;
    logic             w_grant, w_grant_dm, w_fire, w_access, w_misalign;
    logic [15:0]      w_rdata;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign w_misalign = r_addr[0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_grant    = (r_state == IDLE) && (bus.if_req || bus.dm_req);
    // Data wins unless it also took the previous grant and fetch is waiting.
    assign w_grant_dm = bus.dm_req && !(bus.if_req && r_last_dm);
    assign w_fire     = (r_state == BUSY) && (r_cnt == '0);
    assign w_access   = w_fire && !w_misalign;
    assign w_rdata    = (w_access && !r_wr) ? bus.mem_data_out : 16'h0000;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (r_cnt == '0) w_state_nxt = DONE;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_owner    <= OWN_IF;
            r_last_dm  <= 1'b0;
            r_addr     <= 16'h0000;
            r_wr       <= 1'b0;
            r_wdata    <= 16'h0000;
            r_if_rdata <= 16'h0000;
            r_dm_rdata <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant) begin
                r_owner   <= w_grant_dm ? OWN_DM : OWN_IF;
                r_last_dm <= w_grant_dm;
                r_addr    <= w_grant_dm ? bus.dm_addr : bus.if_addr;
                r_wr      <= w_grant_dm && bus.dm_wr;
                r_wdata   <= w_grant_dm ? bus.dm_wdata : 16'h0000;
            end
            if (w_fire) begin
                if (r_owner == OWN_DM) r_dm_rdata <= w_rdata;
                else                   r_if_rdata <= w_rdata;
            end
        end
    end

    assign bus.mem_enable  = w_access;
    assign bus.mem_wr      = w_access && r_wr;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_data_in = w_access ? r_wdata : 16'h0000;
    assign bus.if_done     = (r_state == DONE) && (r_owner == OWN_IF);
    assign bus.dm_done     = (r_state == DONE) && (r_owner == OWN_DM);
    assign bus.if_rdata    = r_if_rdata;
    assign bus.dm_rdata    = r_dm_rdata;
    assign bus.if_stall    = bus.if_req && !bus.if_done;
    assign bus.dm_stall    = bus.dm_req && !bus.dm_done;
    assign bus.err         = (r_state == DONE) && w_misalign;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, hand sequences, randomized run vs transaction model.
`timescale 1ns/1ps
module tb_mem_arbiter;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif
    localparam int L0 = 2;

    logic clk = 1'b0;
    logic rst;
    logic do_init;
    always #5 clk = ~clk;

    mem_arbiter_if b0 ();
    mem_arbiter_if b1 ();

    mem_arbiter #(.LATENCY(L0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mem_arbiter #(.LATENCY(1))  dut1 (.clk(clk), .rst(rst), .bus(b1));

    logic [15:0] mem0 [0:32767];
    logic [15:0] mem1 [0:32767];
    assign b0.mem_data_out = mem0[b0.mem_addr[15:1]];
    assign b1.mem_data_out = mem1[b1.mem_addr[15:1]];

    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 32768; i++) begin
                mem0[i] <= 16'h0000;
                mem1[i] <= 16'h0000;
            end
            mem0[16'h1000 >> 1] <= 16'hABCD;
            mem0[16'h0010 >> 1] <= 16'h7777;
            mem0[16'h0080 >> 1] <= 16'h0BEE;
            mem1[16'h0002 >> 1] <= 16'h00C3;
            mem1[16'h0004 >> 1] <= 16'h00C4;
        end else begin
            if (b0.mem_enable && b0.mem_wr) mem0[b0.mem_addr[15:1]] <= b0.mem_data_in;
            if (b1.mem_enable && b1.mem_wr) mem1[b1.mem_addr[15:1]] <= b1.mem_data_in;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    typedef struct {
        string       nm;
        bit          port;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        bit          exp_err;
        int          exp_en;
    } vec_t;

    vec_t vt [10];

    // One isolated access on the LATENCY=2 port; starts and ends at posedge+1.
    task automatic run_txn(input bit port, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata, output logic [15:0] rd,
                           output int en_c, output int dn_c, output int n_en,
                           output int n_wr, output int n_oth, output bit er,
                           output logic [7:0] smask, output logic [15:0] held);
        bit dn;
        rd = 16'hxxxx; en_c = -1; dn_c = -1; n_en = 0; n_wr = 0; n_oth = 0;
        er = 1'b0; smask = '0;
        if (port) begin
            b0.dm_req = 1'b1; b0.dm_wr = wr; b0.dm_addr = addr; b0.dm_wdata = wdata;
        end else begin
            b0.if_req = 1'b1; b0.if_addr = addr;
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (b0.mem_enable) begin
                n_en++;
                if (en_c < 0) en_c = c;
                if (b0.mem_wr) n_wr++;
            end
            dn = port ? b0.dm_done : b0.if_done;
            if (dn) begin
                dn_c = c;
                rd = port ? b0.dm_rdata : b0.if_rdata;
                er = b0.err;
            end
            if (port ? b0.if_done : b0.dm_done) n_oth++;
            smask[c] = port ? b0.dm_stall : b0.if_stall;
            @(posedge clk); #1;
            if (dn) begin
                b0.dm_req = 1'b0;
                b0.if_req = 1'b0;
            end
        end
        held = port ? b0.dm_rdata : b0.if_rdata;
        b0.dm_req = 1'b0;
        b0.if_req = 1'b0;
    endtask

    // Both ports request at cycle 0; optionally data re-requests right after its done.
    task automatic run_pair(input bit dm_rep, output int dm_d1, output int dm_d2,
                            output int if_d, output logic [15:0] dm_r1,
                            output logic [15:0] dm_r2, output logic [15:0] if_r);
        int  ndm;
        bit  dmd, ifd;
        ndm = 0; dm_d1 = -1; dm_d2 = -1; if_d = -1;
        dm_r1 = 16'hxxxx; dm_r2 = 16'hxxxx; if_r = 16'hxxxx;
        b0.dm_req = 1'b1; b0.dm_wr = 1'b0; b0.dm_addr = 16'h0040;
        b0.if_req = 1'b1; b0.if_addr = 16'h1000;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            dmd = b0.dm_done;
            ifd = b0.if_done;
            if (dmd) begin
                if (ndm == 0) begin dm_d1 = c; dm_r1 = b0.dm_rdata; end
                else          begin dm_d2 = c; dm_r2 = b0.dm_rdata; end
                ndm++;
            end
            if (ifd) begin if_d = c; if_r = b0.if_rdata; end
            @(posedge clk); #1;
            if (dmd) begin
                if (dm_rep && ndm == 1) b0.dm_addr = 16'h0010;
                else                    b0.dm_req  = 1'b0;
            end
            if (ifd) b0.if_req = 1'b0;
        end
        b0.dm_req = 1'b0;
        b0.if_req = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [15:0] gold [0:32767];

    initial begin
        logic [15:0] rd, held, r1, r2, r3;
        int          enc, dnc, nen, nwr, noth, d1, d2, d3, k, ke;
        bit          er;
        logic [7:0]  sm;
        int          en1 [4];
        int          dn1 [4];
        logic [15:0] rd1 [4];
        bit          m_busy, m_own, m_wr, m_last_dm, m_bad, ifd, dmd;
        int          m_next, m_en, m_dn;
        logic [15:0] m_addr, m_wd, m_hif, m_hdm, m_rd;
        bit          e_en, e_ifd, e_dmd;

        b0.if_req = 0; b0.if_addr = 0; b0.dm_req = 0; b0.dm_wr = 0;
        b0.dm_addr = 0; b0.dm_wdata = 0;
        b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_wr = 0;
        b1.dm_addr = 0; b1.dm_wdata = 0;
        for (int i = 0; i < 32768; i++) gold[i] = 16'h0000;
        rst = 1'b1;
        do_init = 1'b1;
        @(posedge clk); #1;
        do_init = 1'b0;

        @(negedge clk);
        chk("rst_mem_enable", b0.mem_enable, 0);
        chk("rst_mem_wr", b0.mem_wr, 0);
        chk("rst_mem_addr", b0.mem_addr, 0);
        chk("rst_mem_data_in", b0.mem_data_in, 0);
        chk("rst_if_done", b0.if_done, 0);
        chk("rst_dm_done", b0.dm_done, 0);
        chk("rst_if_rdata", b0.if_rdata, 0);
        chk("rst_dm_rdata", b0.dm_rdata, 0);
        chk("rst_err", b0.err, 0);
        chk("rst_stalls", {b0.if_stall, b0.dm_stall}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        vt[0] = '{"dm_wr_0040", 1'b1, 1'b1, 16'h0040, 16'h1234, 16'h0000, 1'b0, 2};
        vt[1] = '{"dm_rd_0040", 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h1234, 1'b0, 2};
        vt[2] = '{"if_rd_1000", 1'b0, 1'b0, 16'h1000, 16'h0000, 16'hABCD, 1'b0, 2};
        vt[3] = '{"dm_wr_fffe", 1'b1, 1'b1, 16'hFFFE, 16'h5A5A, 16'h0000, 1'b0, 2};
        vt[4] = '{"if_rd_fffe", 1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h5A5A, 1'b0, 2};
        vt[5] = '{"if_rd_ffff", 1'b0, 1'b0, 16'hFFFF, 16'h0000,
                  ALN ? 16'h0000 : 16'h5A5A, ALN, ALN ? -1 : 2};
        vt[6] = '{"dm_rd_0011", 1'b1, 1'b0, 16'h0011, 16'h0000,
                  ALN ? 16'h0000 : 16'h7777, ALN, ALN ? -1 : 2};
        vt[7] = '{"dm_wr_0013", 1'b1, 1'b1, 16'h0013, 16'h9999, 16'h0000, ALN, ALN ? -1 : 2};
        vt[8] = '{"dm_rd_0012", 1'b1, 1'b0, 16'h0012, 16'h0000,
                  ALN ? 16'h0000 : 16'h9999, 1'b0, 2};
        vt[9] = '{"if_rd_0010", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h7777, 1'b0, 2};

        for (int i = 0; i < 10; i++) begin
            run_txn(vt[i].port, vt[i].wr, vt[i].addr, vt[i].wdata,
                    rd, enc, dnc, nen, nwr, noth, er, sm, held);
            chk({vt[i].nm, "_en_cyc"}, enc, vt[i].exp_en);
            chk({vt[i].nm, "_en_cnt"}, nen, (vt[i].exp_en < 0) ? 0 : 1);
            chk({vt[i].nm, "_wr_cnt"}, nwr, (vt[i].wr && vt[i].exp_en >= 0) ? 1 : 0);
            chk({vt[i].nm, "_done_cyc"}, dnc, L0 + 1);
            chk({vt[i].nm, "_rdata"}, rd, vt[i].exp_rd);
            chk({vt[i].nm, "_err"}, er, vt[i].exp_err);
            chk({vt[i].nm, "_other_done"}, noth, 0);
            chk({vt[i].nm, "_stall"}, sm, 8'b0000_0111);
            chk({vt[i].nm, "_rdata_hold"}, held, vt[i].exp_rd);
        end

        // Reset during cycle 1 of a write: access aborted, outputs clear at once.
        b0.dm_req = 1'b1; b0.dm_wr = 1'b1; b0.dm_addr = 16'h0080; b0.dm_wdata = 16'hDEAD;
        @(posedge clk); #1;
        rst = 1'b1;
        b0.dm_req = 1'b0;
        #1;
        chk("rstmid_mem_enable", b0.mem_enable, 0);
        chk("rstmid_mem_addr", b0.mem_addr, 0);
        chk("rstmid_dones", {b0.if_done, b0.dm_done}, 0);
        chk("rstmid_rdata", {b0.if_rdata, b0.dm_rdata}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        nen = 0; noth = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (b0.mem_enable) nen++;
            if (b0.dm_done || b0.if_done) noth++;
            @(posedge clk); #1;
        end
        chk("rstmid_no_enable", nen, 0);
        chk("rstmid_no_done", noth, 0);
        chk("rstmid_mem_0080", mem0[16'h0080 >> 1], 16'h0BEE);

        run_pair(1'b0, d1, d2, d3, r1, r2, r3);
        chk("coll_dm_done", d1, 3);
        chk("coll_if_done", d3, 7);
        chk("coll_dm_single", d2, -1);
        chk("coll_dm_rdata", r1, 16'h1234);
        chk("coll_if_rdata", r3, 16'hABCD);

        run_pair(1'b1, d1, d2, d3, r1, r2, r3);
        chk("coll2_dm_done1", d1, 3);
        chk("coll2_if_done", d3, 7);
        chk("coll2_dm_done2", d2, 11);
        chk("coll2_dm_rdata2", r2, 16'h7777);

        // LATENCY=1 port: back-to-back reads on a continuously held request.
        k = 0; ke = 0;
        for (int i = 0; i < 4; i++) begin en1[i] = -1; dn1[i] = -1; rd1[i] = 16'hxxxx; end
        b1.dm_req = 1'b1; b1.dm_wr = 1'b0; b1.dm_addr = 16'h0002;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            dmd = b1.dm_done;
            if (b1.mem_enable && ke < 4) begin en1[ke] = c; ke++; end
            if (dmd && k < 4) begin dn1[k] = c; rd1[k] = b1.dm_rdata; k++; end
            @(posedge clk); #1;
            if (dmd) begin
                if (k < 3) b1.dm_addr = (k == 1) ? 16'h0004 : 16'h0002;
                else       b1.dm_req  = 1'b0;
            end
        end
        b1.dm_req = 1'b0;
        chk("l1_en0", en1[0], 1);
        chk("l1_en1", en1[1], 4);
        chk("l1_en2", en1[2], 7);
        chk("l1_done0", dn1[0], 2);
        chk("l1_done1", dn1[1], 5);
        chk("l1_done2", dn1[2], 8);
        chk("l1_rd0", rd1[0], 16'h00C3);
        chk("l1_rd1", rd1[1], 16'h00C4);
        chk("l1_rd2", rd1[2], 16'h00C3);
        chk("l1_extra", {en1[3], dn1[3]}, {-32'sd1, -32'sd1} & 32'hFFFF_FFFF);

        // Randomized traffic against a transaction-level model of the arbiter.
        pulse_reset();
        m_busy = 0; m_next = 0; m_last_dm = 0; m_hif = 0; m_hdm = 0;
        m_own = 0; m_wr = 0; m_addr = 0; m_wd = 0; m_en = -1; m_dn = -1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (!m_busy && c == m_next) begin
                if (b0.if_req || b0.dm_req) begin
                    m_own     = b0.dm_req && !(b0.if_req && m_last_dm);
                    m_last_dm = m_own;
                    m_addr    = m_own ? b0.dm_addr : b0.if_addr;
                    m_wr      = m_own && b0.dm_wr;
                    m_wd      = b0.dm_wdata;
                    m_en      = c + L0;
                    m_dn      = c + L0 + 1;
                    m_busy    = 1'b1;
                end else begin
                    m_next = c + 1;
                end
            end
            m_bad = ALN && m_addr[0];
            e_en  = m_busy && c == m_en && !m_bad;
            e_ifd = m_busy && c == m_dn && !m_own;
            e_dmd = m_busy && c == m_dn && m_own;
            chk("rnd_mem_enable", b0.mem_enable, e_en);
            if (e_en) begin
                chk("rnd_mem_addr", b0.mem_addr, m_addr);
                chk("rnd_mem_wr", b0.mem_wr, m_wr);
                if (m_wr) chk("rnd_mem_data_in", b0.mem_data_in, m_wd);
            end
            if (m_busy && c == m_dn) begin
                m_rd = (m_wr || m_bad) ? 16'h0000 : gold[m_addr[15:1]];
                if (m_own) m_hdm = m_rd; else m_hif = m_rd;
                if (m_wr && !m_bad) gold[m_addr[15:1]] = m_wd;
                m_busy = 1'b0;
                m_next = c + 1;
            end
            chk("rnd_if_done", b0.if_done, e_ifd);
            chk("rnd_dm_done", b0.dm_done, e_dmd);
            chk("rnd_err", b0.err, (e_ifd || e_dmd) && m_bad);
            chk("rnd_if_rdata", b0.if_rdata, m_hif);
            chk("rnd_dm_rdata", b0.dm_rdata, m_hdm);
            chk("rnd_stall", {b0.if_stall, b0.dm_stall},
                {b0.if_req && !e_ifd, b0.dm_req && !e_dmd});
            ifd = b0.if_done;
            dmd = b0.dm_done;
            @(posedge clk); #1;
            if (b0.if_req ? ifd : ($urandom_range(0, 2) == 0)) begin
                b0.if_req  = ($urandom_range(0, 1) == 1) || !b0.if_req;
                b0.if_addr = 16'h2000 + 16'($urandom_range(0, 15) * 2)
                           + 16'($urandom_range(0, 7) == 0);
            end
            if (b0.dm_req ? dmd : ($urandom_range(0, 2) == 0)) begin
                b0.dm_req   = ($urandom_range(0, 1) == 1) || !b0.dm_req;
                b0.dm_wr    = $urandom_range(0, 1) == 1;
                b0.dm_wdata = 16'($urandom);
                b0.dm_addr  = 16'h2000 + 16'($urandom_range(0, 15) * 2)
                            + 16'($urandom_range(0, 7) == 0);
            end
        end
        b0.if_req = 1'b0;
        b0.dm_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
